// File: rtl/apb_manager_n.sv
// APB4 manager: bridges a single CPU-side request port onto NUM_SUB subordinates
// decoded from 4 KiB-aligned regions, with unmapped-address errors and a PREADY timeout.

module apb_manager_n_slice #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 2,
    parameter int K      = 0
) (
    input  logic [IDX_W-1:0]  idx,
    input  logic              active,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic              sel,
    output logic [DATA_W-1:0] rdata,
    output logic              rdy,
    output logic              err
);
    logic hit;

    assign hit   = (idx == IDX_W'(K));
    assign sel   = hit && active;
    assign rdy   = hit && pready;
    assign err   = hit && pslverr;
    assign rdata = hit ? prdata : '0;
endmodule

module apb_manager_n #(
    parameter int          NUM_SUB     = 4,
    parameter int          DATA_W      = 32,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          REGION_BITS = 12,
    parameter int          TIMEOUT_CYC = 255
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    output logic [31:0]               PADDR,
    output logic                      PWRITE,
    output logic                      PENABLE,
    output logic [DATA_W-1:0]         PWDATA,
    output logic [DATA_W/8-1:0]       PSTRB,
    output logic [NUM_SUB-1:0]        PSEL,
    input  logic [NUM_SUB*DATA_W-1:0] PRDATA,
    input  logic [NUM_SUB-1:0]        PREADY,
    input  logic [NUM_SUB-1:0]        PSLVERR,
    input  logic                      transfer,
    input  logic                      write,
    input  logic [31:0]               addr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [DATA_W/8-1:0]       strb,
    output logic [DATA_W-1:0]         rdata,
    output logic                      ready,
    output logic                      error
);
    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (NUM_SUB > 1) ? $clog2(NUM_SUB) : 1;
    localparam int CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;

    typedef struct packed {
        logic              write;
        logic [31:0]       addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
        logic [IDX_W-1:0]  idx;
    } req_t;

    state_t            state;
    req_t              hold;
    logic [CNT_W-1:0]  wait_cnt;

    logic [31:0]       offset;
    logic              in_mapped;
    logic [IDX_W-1:0]  in_idx;
    logic              active;

    logic [NUM_SUB-1:0]             sub_sel, sub_rdy, sub_err;
    logic [NUM_SUB-1:0][DATA_W-1:0] sub_rdata;
    logic [DATA_W-1:0]              sel_rdata;
    logic                           sel_ready, sel_err;

    logic timeout_hit, access_done, accept;

    // Decode the incoming address; the result is latched with the request.
    assign offset    = addr - BASE_ADDR;
    assign in_mapped = (addr >= BASE_ADDR) && ((offset >> REGION_BITS) < 32'(NUM_SUB));
    assign in_idx    = offset[REGION_BITS +: IDX_W];

    assign active = (state == SETUP) || (state == ACCESS);

    genvar k;
    generate
        for (k = 0; k < NUM_SUB; k++) begin : g_sub
            apb_manager_n_slice #(
                .DATA_W (DATA_W),
                .IDX_W  (IDX_W),
                .K      (k)
            ) u_slice (
                .idx     (hold.idx),
                .active  (active),
                .prdata  (PRDATA[k*DATA_W +: DATA_W]),
                .pready  (PREADY[k]),
                .pslverr (PSLVERR[k]),
                .sel     (sub_sel[k]),
                .rdata   (sub_rdata[k]),
                .rdy     (sub_rdy[k]),
                .err     (sub_err[k])
            );
        end
    endgenerate

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SUB; i++) sel_rdata = sel_rdata | sub_rdata[i];
    end

    assign sel_ready = |sub_rdy;
    assign sel_err   = |sub_err;

    // PREADY wins over the timeout when both land in the same cycle.
    assign timeout_hit = (TIMEOUT_CYC != 0) && (state == ACCESS) && !sel_ready
                         && (wait_cnt == CNT_W'(TIMEOUT_CYC));
    assign access_done = (state == ACCESS) && (sel_ready || timeout_hit);

    assign ready  = access_done || (state == ERR);
    assign error  = (state == ERR) || timeout_hit || ((state == ACCESS) && sel_ready && sel_err);
    assign rdata  = ((state == ACCESS) && sel_ready && !hold.write) ? sel_rdata : '0;
    assign accept = transfer && ((state == IDLE) || ready);

    assign PADDR   = hold.addr;
    assign PWRITE  = hold.write;
    assign PWDATA  = hold.wdata;
    assign PSTRB   = hold.strb;
    assign PSEL    = sub_sel;
    assign PENABLE = (state == ACCESS);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= IDLE;
            hold     <= '0;
            wait_cnt <= '0;
        end else begin
            if (accept) begin
                hold.write <= write;
                hold.addr  <= addr;
                hold.wdata <= wdata;
                hold.strb  <= write ? strb : '0;
                hold.idx   <= in_idx;
                state      <= in_mapped ? SETUP : ERR;
            end else begin
                case (state)
                    SETUP:   state <= ACCESS;
                    ACCESS:  if (access_done) state <= IDLE;
                    ERR:     state <= IDLE;
                    default: state <= IDLE;
                endcase
            end

            if (state == SETUP)
                wait_cnt <= '0;
            else if ((state == ACCESS) && !sel_ready)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_apb_manager_n.sv
// Directed bench for apb_manager_n: zero-wait RAM, wait states, slave and decode
// errors, timeout, back-to-back transfers and asynchronous reset mid-access.

module tb_apb_manager_n;
    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [31:0] PADDR;
    logic        PWRITE, PENABLE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [3:0]  PSEL;
    logic [127:0] PRDATA;
    logic [3:0]  PREADY, PSLVERR;
    logic        transfer, write;
    logic [31:0] addr, wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic        ready, error;

    logic [31:0] mem [4];
    logic [31:0] rd1, rd2, rd3;
    int checks = 0;
    int errors = 0;

    apb_manager_n #(
        .NUM_SUB     (4),
        .DATA_W      (32),
        .BASE_ADDR   (32'h1000_0000),
        .REGION_BITS (12),
        .TIMEOUT_CYC (4)
    ) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .PADDR    (PADDR),
        .PWRITE   (PWRITE),
        .PENABLE  (PENABLE),
        .PWDATA   (PWDATA),
        .PSTRB    (PSTRB),
        .PSEL     (PSEL),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .transfer (transfer),
        .write    (write),
        .addr     (addr),
        .wdata    (wdata),
        .strb     (strb),
        .rdata    (rdata),
        .ready    (ready),
        .error    (error)
    );

    always #5 PCLK = ~PCLK;

    // Subordinate 0 is a small RAM honouring byte strobes.
    assign PRDATA = {rd3, rd2, rd1, mem[PADDR[3:2]]};
    always @(negedge PCLK) begin
        if (PSEL[0] && PENABLE && PWRITE && PREADY[0])
            for (int b = 0; b < 4; b++)
                if (PSTRB[b]) mem[PADDR[3:2]][b*8 +: 8] <= PWDATA[b*8 +: 8];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        transfer = 1'b1;
        write    = w;
        addr     = a;
        wdata    = d;
        strb     = s;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mem[i] = '0;
        PRESETn = 1'b0;
        transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0; strb = '0;
        PREADY = 4'hF; PSLVERR = 4'h0;
        rd1 = 32'h1111_1111; rd2 = 32'h2222_2222; rd3 = 32'h3333_3333;

        // Reset state
        #12;
        chk("rst_paddr", PADDR, 32'h0);
        chk("rst_psel", {28'h0, PSEL}, 32'h0);
        chk("rst_penable", {31'h0, PENABLE}, 32'h0);
        chk("rst_pstrb", {28'h0, PSTRB}, 32'h0);
        chk("rst_ready", {31'h0, ready}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        PRESETn = 1'b1;

        // Write then read, zero-wait RAM
        step();
        req(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF); #1;
        chk("t1_idle_ready", {31'h0, ready}, 32'h0);
        step();
        chk("t1_setup_psel", {28'h0, PSEL}, 32'h1);
        chk("t1_setup_penable", {31'h0, PENABLE}, 32'h0);
        chk("t1_setup_paddr", PADDR, 32'h1000_0004);
        chk("t1_setup_pwrite", {31'h0, PWRITE}, 32'h1);
        chk("t1_setup_pstrb", {28'h0, PSTRB}, 32'hF);
        chk("t1_setup_pwdata", PWDATA, 32'hDEAD_BEEF);
        step();
        chk("t1_acc_penable", {31'h0, PENABLE}, 32'h1);
        chk("t1_wr_ready", {31'h0, ready}, 32'h1);
        chk("t1_wr_error", {31'h0, error}, 32'h0);
        chk("t1_wr_rdata", rdata, 32'h0);
        req(1'b0, 32'h1000_0004, 32'h0, 4'hF); #1;
        step();
        chk("t1_rd_psel", {28'h0, PSEL}, 32'h1);
        chk("t1_rd_pwrite", {31'h0, PWRITE}, 32'h0);
        chk("t1_rd_pstrb", {28'h0, PSTRB}, 32'h0);
        step();
        chk("t1_rd_ready", {31'h0, ready}, 32'h1);
        chk("t1_rd_rdata", rdata, 32'hDEAD_BEEF);
        chk("t1_rd_error", {31'h0, error}, 32'h0);
        transfer = 1'b0; #1;
        step();
        chk("t1_idle_ready2", {31'h0, ready}, 32'h0);
        chk("t1_idle_psel", {28'h0, PSEL}, 32'h0);
        chk("t1_idle_paddr_kept", PADDR, 32'h1000_0004);

        // Wait states and byte strobes on subordinate 2
        PREADY[2] = 1'b0;
        req(1'b1, 32'h1000_2010, 32'hA5A5_1234, 4'b0011); #1;
        step();
        chk("t2_setup_psel", {28'h0, PSEL}, 32'h4);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_wait_penable", {31'h0, PENABLE}, 32'h1);
            chk("t2_wait_ready", {31'h0, ready}, 32'h0);
            chk("t2_wait_paddr", PADDR, 32'h1000_2010);
            chk("t2_wait_pwdata", PWDATA, 32'hA5A5_1234);
            chk("t2_wait_pstrb", {28'h0, PSTRB}, 32'h3);
        end
        step();
        PREADY[2] = 1'b1; #1;
        chk("t2_done_penable", {31'h0, PENABLE}, 32'h1);
        chk("t2_done_ready", {31'h0, ready}, 32'h1);
        chk("t2_done_error", {31'h0, error}, 32'h0);
        transfer = 1'b0; #1;
        step();
        chk("t2_after_ready", {31'h0, ready}, 32'h0);
        chk("t2_after_penable", {31'h0, PENABLE}, 32'h0);

        // Slave error, then unmapped address back-to-back
        PSLVERR[1] = 1'b1;
        req(1'b0, 32'h1000_1000, 32'h0, 4'h0); #1;
        step();
        chk("t3_setup_psel", {28'h0, PSEL}, 32'h2);
        step();
        chk("t3_slverr_ready", {31'h0, ready}, 32'h1);
        chk("t3_slverr_error", {31'h0, error}, 32'h1);
        chk("t3_slverr_rdata", rdata, 32'h1111_1111);
        req(1'b0, 32'h2000_0000, 32'h0, 4'h0); #1;
        step();
        PSLVERR[1] = 1'b0; transfer = 1'b0; #1;
        chk("t3_unmap_psel", {28'h0, PSEL}, 32'h0);
        chk("t3_unmap_ready", {31'h0, ready}, 32'h1);
        chk("t3_unmap_error", {31'h0, error}, 32'h1);
        chk("t3_unmap_rdata", rdata, 32'h0);
        step();
        chk("t3_idle_ready", {31'h0, ready}, 32'h0);
        chk("t3_idle_error", {31'h0, error}, 32'h0);

        // Timeout on subordinate 3
        PREADY[3] = 1'b0;
        req(1'b0, 32'h1000_3000, 32'h0, 4'h0); #1;
        step();
        chk("t4_setup_psel", {28'h0, PSEL}, 32'h8);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_wait_penable", {31'h0, PENABLE}, 32'h1);
            chk("t4_wait_ready", {31'h0, ready}, 32'h0);
        end
        step();
        chk("t4_to_ready", {31'h0, ready}, 32'h1);
        chk("t4_to_error", {31'h0, error}, 32'h1);
        chk("t4_to_rdata", rdata, 32'h0);
        transfer = 1'b0; #1;
        step();
        chk("t4_after_psel", {28'h0, PSEL}, 32'h0);
        chk("t4_after_ready", {31'h0, ready}, 32'h0);
        PREADY[3] = 1'b1;

        // Back-to-back: sub 0, sub 1, below-base, just-past-last-region
        req(1'b0, 32'h1000_0004, 32'h0, 4'h0); #1;
        chk("t5_n_ready", {31'h0, ready}, 32'h0);
        step();
        chk("t5_n1_psel", {28'h0, PSEL}, 32'h1);
        chk("t5_n1_ready", {31'h0, ready}, 32'h0);
        step();
        chk("t5_n2_ready", {31'h0, ready}, 32'h1);
        chk("t5_n2_rdata", rdata, 32'hDEAD_BEEF);
        req(1'b0, 32'h1000_1008, 32'h0, 4'h0); #1;
        step();
        chk("t5_n3_psel", {28'h0, PSEL}, 32'h2);
        chk("t5_n3_ready", {31'h0, ready}, 32'h0);
        step();
        chk("t5_n4_ready", {31'h0, ready}, 32'h1);
        chk("t5_n4_rdata", rdata, 32'h1111_1111);
        chk("t5_n4_error", {31'h0, error}, 32'h0);
        req(1'b0, 32'h0FFF_FFFC, 32'h0, 4'h0); #1;
        step();
        chk("t5_n5_psel", {28'h0, PSEL}, 32'h0);
        chk("t5_n5_ready", {31'h0, ready}, 32'h1);
        chk("t5_n5_error", {31'h0, error}, 32'h1);
        req(1'b0, 32'h1000_4000, 32'h0, 4'h0); #1;
        step();
        transfer = 1'b0; #1;
        chk("t5_n6_psel", {28'h0, PSEL}, 32'h0);
        chk("t5_n6_ready", {31'h0, ready}, 32'h1);
        chk("t5_n6_error", {31'h0, error}, 32'h1);
        step();
        chk("t5_n7_ready", {31'h0, ready}, 32'h0);

        // Asynchronous reset during ACCESS
        PREADY[2] = 1'b0;
        req(1'b1, 32'h1000_2000, 32'h5555_AAAA, 4'hF); #1;
        step();
        step();
        chk("t6_acc_penable", {31'h0, PENABLE}, 32'h1);
        PRESETn = 1'b0; #1;
        chk("t6_rst_paddr", PADDR, 32'h0);
        chk("t6_rst_pwdata", PWDATA, 32'h0);
        chk("t6_rst_pwrite", {31'h0, PWRITE}, 32'h0);
        chk("t6_rst_pstrb", {28'h0, PSTRB}, 32'h0);
        chk("t6_rst_psel", {28'h0, PSEL}, 32'h0);
        chk("t6_rst_penable", {31'h0, PENABLE}, 32'h0);
        chk("t6_rst_ready", {31'h0, ready}, 32'h0);
        chk("t6_rst_error", {31'h0, error}, 32'h0);
        transfer = 1'b0; PREADY[2] = 1'b1;
        step();
        step();
        PRESETn = 1'b1;
        step();
        req(1'b0, 32'h1000_0004, 32'h0, 4'h0); #1;
        chk("t6_new_idle_ready", {31'h0, ready}, 32'h0);
        step();
        chk("t6_new_psel", {28'h0, PSEL}, 32'h1);
        step();
        chk("t6_new_ready", {31'h0, ready}, 32'h1);
        chk("t6_new_rdata", rdata, 32'hDEAD_BEEF);
        transfer = 1'b0; #1;
        step();
        chk("t6_new_idle", {31'h0, ready}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
